// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared FSM state and mode encodings for the sequential binary FC layer
package bnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EVAL  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic MODE_THR    = 1'b0;
  localparam logic MODE_ARGMAX = 1'b1;

endpackage

// File: rtl/bnn_popcount.sv
// rtl/bnn_popcount.sv - combinational XNOR-popcount of two equal-width vectors
module bnn_popcount #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i] == b[i]) cnt = cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bnn_seq_fc.sv
// rtl/bnn_seq_fc.sv - sequential binary fully-connected layer, one weight word per beat,
// producing either thresholded neuron outputs or the argmax neuron and its score
module bnn_seq_fc
  import bnn_pkg::*;
#(
  parameter  int IN_SIZE     = 128,
  parameter  int NUM_NEURONS = 10,
  parameter  int WORD_W      = 16,
  localparam int WPN         = IN_SIZE / WORD_W,
  localparam int CNT_W       = $clog2(IN_SIZE + 1),
  localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         mode,
  input  logic [IN_SIZE-1:0]           in_vec,
  input  logic [NUM_NEURONS*CNT_W-1:0] thr,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [WORD_W-1:0]            w_data,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_NEURONS-1:0]       out_vec,
  output logic [IDX_W-1:0]             class_idx,
  output logic [CNT_W-1:0]             class_score
);

  localparam int WI_W = (WPN > 1) ? $clog2(WPN) : 1;
  localparam int PC_W = $clog2(WORD_W + 1);

  state_e                       state_q, state_d;
  logic                         mode_q, mode_d;
  logic [IN_SIZE-1:0]           in_vec_q, in_vec_d;
  logic [NUM_NEURONS*CNT_W-1:0] thr_q, thr_d;
  logic [CNT_W-1:0]             acc_q, acc_d;
  logic [WI_W-1:0]              word_idx_q, word_idx_d;
  logic [IDX_W-1:0]             neuron_idx_q, neuron_idx_d;
  logic [NUM_NEURONS-1:0]       out_vec_q, out_vec_d;
  logic [IDX_W-1:0]             class_idx_q, class_idx_d;
  logic [CNT_W-1:0]             class_score_q, class_score_d;

  logic [WORD_W-1:0] cur_word;
  logic [CNT_W-1:0]  cur_thr;
  logic [PC_W-1:0]   beat_pc;

  assign cur_word = in_vec_q[word_idx_q*WORD_W +: WORD_W];
  assign cur_thr  = thr_q[neuron_idx_q*CNT_W +: CNT_W];

  bnn_popcount #(.WIDTH(WORD_W)) u_popcount (
    .a   (w_data),
    .b   (cur_word),
    .cnt (beat_pc)
  );

  // Handshake and status decode straight from the state so reset clears them at once
  assign w_ready     = (state_q == S_ACCUM);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign out_vec     = out_vec_q;
  assign class_idx   = class_idx_q;
  assign class_score = class_score_q;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    in_vec_d      = in_vec_q;
    thr_d         = thr_q;
    acc_d         = acc_q;
    word_idx_d    = word_idx_q;
    neuron_idx_d  = neuron_idx_q;
    out_vec_d     = out_vec_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d        = mode;
          in_vec_d      = in_vec;
          thr_d         = thr;
          acc_d         = '0;
          word_idx_d    = '0;
          neuron_idx_d  = '0;
          out_vec_d     = '0;
          class_idx_d   = '0;
          class_score_d = '0;
          state_d       = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_valid) begin
          acc_d      = acc_q + CNT_W'(beat_pc);
          word_idx_d = word_idx_q + WI_W'(1);
          if (word_idx_q == WI_W'(WPN - 1)) state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (mode_q == MODE_THR) begin
          out_vec_d[neuron_idx_q] = (acc_q >= cur_thr);
        end else if ((neuron_idx_q == '0) || (acc_q > class_score_q)) begin
          // Strict compare keeps the lowest index on ties
          class_score_d = acc_q;
          class_idx_d   = neuron_idx_q;
        end
        acc_d        = '0;
        word_idx_d   = '0;
        neuron_idx_d = neuron_idx_q + IDX_W'(1);
        state_d      = (neuron_idx_q == IDX_W'(NUM_NEURONS - 1)) ? S_DONE : S_ACCUM;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      mode_q        <= MODE_THR;
      in_vec_q      <= '0;
      thr_q         <= '0;
      acc_q         <= '0;
      word_idx_q    <= '0;
      neuron_idx_q  <= '0;
      out_vec_q     <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      in_vec_q      <= in_vec_d;
      thr_q         <= thr_d;
      acc_q         <= acc_d;
      word_idx_q    <= word_idx_d;
      neuron_idx_q  <= neuron_idx_d;
      out_vec_q     <= out_vec_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
    end
  end

endmodule

// File: tb/tb_bnn_seq_fc.sv
// tb/tb_bnn_seq_fc.sv - randomized self-checking bench for bnn_seq_fc against a score-level model
module tb_bnn_seq_fc;

  localparam int IN_SIZE     = 32;
  localparam int WORD_W      = 8;
  localparam int NUM_NEURONS = 4;
  localparam int WPN         = IN_SIZE / WORD_W;
  localparam int CNT_W       = 6;
  localparam int IDX_W       = 2;
  localparam int NB          = NUM_NEURONS * WPN;
  localparam int BASE_LAT    = NUM_NEURONS * (WPN + 1) + 1;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic                         mode = 1'b0;
  logic [IN_SIZE-1:0]           in_vec = '0;
  logic [NUM_NEURONS*CNT_W-1:0] thr = '0;
  logic                         w_valid = 1'b0;
  logic                         w_ready;
  logic [WORD_W-1:0]            w_data = '0;
  logic                         busy;
  logic                         done;
  logic [NUM_NEURONS-1:0]       out_vec;
  logic [IDX_W-1:0]             class_idx;
  logic [CNT_W-1:0]             class_score;

  always #5 clk = ~clk;

  bnn_seq_fc #(
    .IN_SIZE     (IN_SIZE),
    .NUM_NEURONS (NUM_NEURONS),
    .WORD_W      (WORD_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .in_vec      (in_vec),
    .thr         (thr),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .busy        (busy),
    .done        (done),
    .out_vec     (out_vec),
    .class_idx   (class_idx),
    .class_score (class_score)
  );

  int checks = 0;
  int errors = 0;

  logic [WORD_W-1:0]      wts [NB];
  logic [NUM_NEURONS-1:0] exp_out;
  logic [IDX_W-1:0]       exp_idx;
  logic [CNT_W-1:0]       exp_score;
  bit                     hold_valid = 1'b0;
  bit                     running = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Score = number of input bits whose weight bit agrees, counted over the whole vector
  task automatic model(input logic m, input logic [IN_SIZE-1:0] iv,
                       input logic [NUM_NEURONS*CNT_W-1:0] th);
    int sc [NUM_NEURONS];
    int best;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      sc[n] = 0;
      for (int b = 0; b < IN_SIZE; b++)
        if (wts[n*WPN + b/WORD_W][b%WORD_W] == iv[b]) sc[n]++;
    end
    exp_out = '0;
    exp_idx = '0;
    exp_score = '0;
    if (m == 1'b0) begin
      for (int n = 0; n < NUM_NEURONS; n++)
        exp_out[n] = (sc[n] >= int'(th[n*CNT_W +: CNT_W]));
    end else begin
      best = 0;
      for (int n = 1; n < NUM_NEURONS; n++)
        if (sc[n] > sc[best]) best = n;
      exp_idx = IDX_W'(best);
      exp_score = CNT_W'(sc[best]);
    end
  endtask

  always @(negedge clk) begin
    if (hold_valid) begin
      chk("hold_out_vec", out_vec, exp_out);
      chk("hold_class_idx", class_idx, exp_idx);
      chk("hold_class_score", class_score, exp_score);
    end
    if (running) chk("busy_during_run", busy, 1);
  end

  // smode: 0 = w_valid always high, 1 = low on alternate ACCUM cycles, 2 = random
  task automatic run(input logic m, input logic [IN_SIZE-1:0] iv,
                     input logic [NUM_NEURONS*CNT_W-1:0] th,
                     input int smode, input bit pulse, output int lat);
    int  beat = 0;
    int  stalls = 0;
    int  cyc;
    bit  rdy;
    bit  tog = 1'b0;
    bit  seen = 1'b0;
    model(m, iv, th);
    hold_valid = 1'b0;
    @(negedge clk);
    mode = m;
    in_vec = iv;
    thr = th;
    start = 1'b1;
    w_valid = 1'b0;
    @(posedge clk);
    cyc = 1;
    #1;
    running = 1'b1;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      start = pulse && (cyc == 5);
      in_vec = $urandom;
      thr = 24'($urandom);
      mode = 1'($urandom);
      rdy = w_ready;
      w_data = wts[(beat < NB) ? beat : NB-1];
      case (smode)
        0: w_valid = 1'b1;
        1: begin
          w_valid = rdy ? tog : 1'b0;
          if (rdy) tog = ~tog;
        end
        default: w_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (rdy && !w_valid) stalls++;
      @(posedge clk);
      cyc++;
      if (rdy && w_valid) beat++;
      #1;
      if (done) seen = 1'b1;
    end
    running = 1'b0;
    start = 1'b0;
    w_valid = 1'b0;
    lat = cyc;
    chk("done_seen", seen, 1);
    chk("latency", cyc, BASE_LAT + stalls);
    chk("beats_taken", beat, NB);
    chk("out_vec", out_vec, exp_out);
    chk("class_idx", class_idx, exp_idx);
    chk("class_score", class_score, exp_score);
    hold_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic [IN_SIZE-1:0] iv;
    logic [NUM_NEURONS*CNT_W-1:0] th;
    logic [WORD_W-1:0] amax [NB] = '{8'h00, 8'hFC, 8'hFF, 8'hFF,
                                     8'h00, 8'h00, 8'hF0, 8'hFF,
                                     8'h00, 8'h00, 8'hF0, 8'hFF,
                                     8'hE0, 8'hFF, 8'hFF, 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_class_score", class_score, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < NB; i++) wts[i] = 8'hFF;
    run(1'b0, '1, {NUM_NEURONS{6'd32}}, 0, 1'b0, lat);
    chk("all_ones_out", out_vec, 4'b1111);
    chk("all_ones_lat", lat, 21);

    run(1'b0, '1, {NUM_NEURONS{6'd32}}, 1, 1'b0, lat);
    chk("stall_out", out_vec, 4'b1111);
    chk("stall_lat", lat, 37);

    iv = $urandom;
    for (int n = 0; n < NUM_NEURONS; n++)
      for (int k = 0; k < WPN; k++)
        wts[n*WPN + k] = (n == 2) ? ~iv[k*WORD_W +: WORD_W] : iv[k*WORD_W +: WORD_W];
    run(1'b0, iv, {NUM_NEURONS{6'd1}}, 2, 1'b0, lat);
    chk("inv_neuron2_out", out_vec, 4'b1011);

    for (int i = 0; i < NB; i++) wts[i] = amax[i];
    run(1'b0, '0, 24'($urandom), 0, 1'b0, lat);
    run(1'b1, '0, 24'($urandom), 0, 1'b0, lat);
    chk("argmax_idx", class_idx, 1);
    chk("argmax_score", class_score, 20);
    chk("argmax_out_vec", out_vec, 0);

    for (int i = 0; i < NB; i++) wts[i] = 8'hFF;
    run(1'b0, '1, {NUM_NEURONS{6'd32}}, 0, 1'b1, lat);
    chk("mid_start_out", out_vec, 4'b1111);
    chk("mid_start_lat", lat, 21);

    hold_valid = 1'b0;
    @(negedge clk);
    mode = 1'b1;
    in_vec = '0;
    start = 1'b1;
    w_valid = 1'b1;
    w_data = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_busy", busy, 1);
    chk("pre_reset_score", class_score, 32);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_w_ready", w_ready, 0);
    chk("abort_out_vec", out_vec, 0);
    chk("abort_class_idx", class_idx, 0);
    chk("abort_class_score", class_score, 0);
    w_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run(1'b0, '1, {NUM_NEURONS{6'd32}}, 0, 1'b0, lat);
    chk("post_reset_lat", lat, 21);
    chk("post_reset_out", out_vec, 4'b1111);

    repeat (25) begin
      for (int i = 0; i < NB; i++) wts[i] = 8'($urandom);
      iv = $urandom;
      for (int n = 0; n < NUM_NEURONS; n++) th[n*CNT_W +: CNT_W] = 6'($urandom_range(10, 22));
      run(1'($urandom), iv, th, $urandom_range(0, 2), 1'($urandom), lat);
    end

    hold_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
